// File: rtl/cms_axis_pkg.sv
// ---------------------------------------------------------------------------
// cms_axis_pkg
//   Shared definitions for the CMS AXI-Stream output path.
//   - CMS_AXI_DATA_WIDTH : width of one CMS output item
//   - CMS_DMA_DATA_WIDTH : width of the DMA / FIFO beat
//   - downsizer_state_t  : downsizer control states
// ---------------------------------------------------------------------------
package cms_axis_pkg;

    localparam int CMS_AXI_DATA_WIDTH = 1024;
    localparam int CMS_DMA_DATA_WIDTH = 64;

    typedef enum logic {
        IDLE = 1'b0,  // buffer empty, ready for a new wide item
        SEND = 1'b1   // buffer holds an item, emitting narrow beats
    } downsizer_state_t;

endpackage : cms_axis_pkg

// File: rtl/cms_axis_downsizer.sv
// ---------------------------------------------------------------------------
// cms_axis_downsizer
//   Serialises one wide AXI-Stream item into narrow beats, least-significant
//   word first. Only the low 'active_words' words of each item are sent, so
//   padding never reaches memory. Item boundaries and tlast are preserved.
//   Back-to-back items incur no bubble: the next item loads on the same
//   cycle that the last beat of the current item handshakes.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   S_AXIS_*        : wide slave stream (tvalid, tready, tdata, tlast)
//   M_AXIS_*        : narrow master stream (tvalid, tready, tdata, tlast)
//   active_words    : words sent per item, sampled at item capture;
//                     0 or values above RATIO mean the full RATIO words
//
// Optional build macro
//   CMS_AXIS_DOWNSIZER_STATS_EN : adds stats_clear input plus items_sent and
//                     beats_sent 32-bit wrapping counters.
// ---------------------------------------------------------------------------
module cms_axis_downsizer
    import cms_axis_pkg::*;
#(
    parameter  int S_DATA_WIDTH = CMS_AXI_DATA_WIDTH,
    parameter  int M_DATA_WIDTH = CMS_DMA_DATA_WIDTH,
    localparam int RATIO        = S_DATA_WIDTH / M_DATA_WIDTH,
    localparam int IDX_W        = $clog2(RATIO) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    S_AXIS_tvalid,
    output logic                    S_AXIS_tready,
    input  logic [S_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                    S_AXIS_tlast,

    output logic                    M_AXIS_tvalid,
    input  logic                    M_AXIS_tready,
    output logic [M_DATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                    M_AXIS_tlast,

    input  logic [IDX_W-1:0]        active_words
`ifdef CMS_AXIS_DOWNSIZER_STATS_EN
    ,
    input  logic                    stats_clear,
    output logic [31:0]             items_sent,
    output logic [31:0]             beats_sent
`endif
);

    downsizer_state_t  state_q, state_d;

    logic [S_DATA_WIDTH-1:0] buf_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        n_words_q;
    logic                    last_q;

    logic [IDX_W-1:0]        n_words_sel;
    logic                    last_beat;
    logic                    s_ready;
    logic                    capture;
    logic                    m_fire;

    // Out-of-range or zero requests fall back to sending the whole item.
    assign n_words_sel = (active_words == '0 || active_words > IDX_W'(RATIO))
                         ? IDX_W'(RATIO) : active_words;

    assign last_beat = (idx_q == n_words_q - IDX_W'(1));
    assign capture   = S_AXIS_tvalid && S_AXIS_tready;
    assign m_fire    = M_AXIS_tvalid && M_AXIS_tready;

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // pre-edge values regardless of process ordering.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case,
        // so no path leaves a signal unassigned and no latch is inferred.
        state_d       = state_q;
        s_ready       = 1'b0;
        M_AXIS_tvalid = 1'b0;
        unique case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (S_AXIS_tvalid) state_d = SEND;
            end
            SEND: begin
                M_AXIS_tvalid = 1'b1;
                // Accept the next item in the same cycle the last beat leaves.
                if (last_beat && M_AXIS_tready) begin
                    s_ready = 1'b1;
                    if (!S_AXIS_tvalid) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Not ready while reset is held, even though the state reads IDLE.
    assign S_AXIS_tready = s_ready && rst_n;
    assign M_AXIS_tlast  = (state_q == SEND) && last_beat && last_q;

    // ---------------------------------------------------------------------
    // Item buffer and word index
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the wide buffer is reset on purpose so M_AXIS_tdata reads 0
        // out of reset; storage that may power up unknown is usually not.
        if (!rst_n) begin
            buf_q     <= '0;
            idx_q     <= '0;
            n_words_q <= IDX_W'(RATIO);
            last_q    <= 1'b0;
        end else if (capture) begin
            buf_q     <= S_AXIS_tdata;
            idx_q     <= '0;
            n_words_q <= n_words_sel;
            last_q    <= S_AXIS_tlast;
        end else if (m_fire) begin
            // Park at word 0 after the last beat so the select never leaves
            // the buffer while idle.
            idx_q <= last_beat ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Word select from registered state only; constant-indexed mux.
    always_comb begin
        M_AXIS_tdata = '0;
        for (int w = 0; w < RATIO; w++) begin
            if (idx_q == IDX_W'(w)) M_AXIS_tdata = buf_q[w*M_DATA_WIDTH +: M_DATA_WIDTH];
        end
    end

`ifdef CMS_AXIS_DOWNSIZER_STATS_EN
    // ---------------------------------------------------------------------
    // Statistics: clear has priority over a same-cycle increment.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            items_sent <= '0;
            beats_sent <= '0;
        end else if (stats_clear) begin
            items_sent <= '0;
            beats_sent <= '0;
        end else begin
            if (m_fire && last_beat) items_sent <= items_sent + 32'd1;
            if (m_fire)              beats_sent <= beats_sent + 32'd1;
        end
    end
`endif

endmodule : cms_axis_downsizer

// File: tb/tb_cms_axis_downsizer.sv
// ---------------------------------------------------------------------------
// tb_cms_axis_downsizer
//   Directed bench for cms_axis_downsizer with default widths (1024 -> 64).
//   Inputs change and outputs are checked just after the falling edge.
// ---------------------------------------------------------------------------
module tb_cms_axis_downsizer;

    localparam int SW    = 1024;
    localparam int MW    = 64;
    localparam int RATIO = 16;
    localparam int IDX_W = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_tvalid;
    logic            s_tready;
    logic [SW-1:0]   s_tdata;
    logic            s_tlast;
    logic            m_tvalid;
    logic            m_tready;
    logic [MW-1:0]   m_tdata;
    logic            m_tlast;
    logic [IDX_W-1:0] active_words;
`ifdef CMS_AXIS_DOWNSIZER_STATS_EN
    logic            stats_clear;
    logic [31:0]     items_sent;
    logic [31:0]     beats_sent;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cms_axis_downsizer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tready (s_tready),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tlast  (s_tlast),
        .M_AXIS_tvalid (m_tvalid),
        .M_AXIS_tready (m_tready),
        .M_AXIS_tdata  (m_tdata),
        .M_AXIS_tlast  (m_tlast),
        .active_words  (active_words)
`ifdef CMS_AXIS_DOWNSIZER_STATS_EN
        ,
        .stats_clear   (stats_clear),
        .items_sent    (items_sent),
        .beats_sent    (beats_sent)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle later, shortly after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Item whose word i holds base + i.
    function automatic logic [SW-1:0] mk_item(input logic [63:0] base);
        logic [SW-1:0] r;
        r = '0;
        for (int i = 0; i < RATIO; i++) r[i*MW +: MW] = base + 64'(i);
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bp_pat [4];
        int   bp_idx;
        int   bp_cyc;

        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst_n        = 1'b0;
        s_tvalid     = 1'b0;
        s_tdata      = '0;
        s_tlast      = 1'b0;
        m_tready     = 1'b0;
        active_words = '0;
`ifdef CMS_AXIS_DOWNSIZER_STATS_EN
        stats_clear  = 1'b0;
`endif

        // ---------------- reset state ----------------
        tick(); tick(); #1;
        check("rst_mvalid", m_tvalid, 0);
        check("rst_mtdata", m_tdata, 0);
        check("rst_mtlast", m_tlast, 0);
        check("rst_sready", s_tready, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("idle_sready", s_tready, 1);
        check("idle_mvalid", m_tvalid, 0);

        // ---------------- full-width item ----------------
        tick();
        active_words = 0;
        m_tready     = 1'b1;
        s_tdata      = mk_item(64'h0);
        s_tlast      = 1'b1;
        s_tvalid     = 1'b1;
        #1;
        check("full_cap_sready", s_tready, 1);
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 0) s_tvalid = 1'b0;
            #1;
            check($sformatf("full_mvalid%0d", k), m_tvalid, 1);
            check($sformatf("full_data%0d", k), m_tdata, 64'(k));
            check($sformatf("full_tlast%0d", k), m_tlast, (k == 15));
            check($sformatf("full_sready%0d", k), s_tready, (k == 15));
        end
        tick(); #1;
        check("full_done_mvalid", m_tvalid, 0);

`ifdef CMS_AXIS_DOWNSIZER_STATS_EN
        tick();
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
`endif

        // ---------------- trimmed back-to-back items ----------------
        tick();
        active_words = 3;
        s_tdata      = mk_item(64'hA00);
        s_tlast      = 1'b0;
        s_tvalid     = 1'b1;
        #1;
        check("trim_capA_sready", s_tready, 1);
        tick();
        s_tdata = mk_item(64'hB00);
        s_tlast = 1'b1;
        #1;
        check("trim_A0", m_tdata, 64'hA00);
        check("trim_A0_tlast", m_tlast, 0);
        check("trim_A0_sready", s_tready, 0);
        tick(); #1;
        check("trim_A1", m_tdata, 64'hA01);
        check("trim_A1_sready", s_tready, 0);
        tick(); #1;
        check("trim_A2", m_tdata, 64'hA02);
        check("trim_A2_tlast", m_tlast, 0);
        check("trim_A2_sready", s_tready, 1);
        tick();
        s_tvalid     = 1'b0;
        active_words = 20;  // mid-item change must not affect item B
        #1;
        check("trim_B0_mvalid", m_tvalid, 1);
        check("trim_B0", m_tdata, 64'hB00);
        check("trim_B0_tlast", m_tlast, 0);
        tick(); #1;
        check("trim_B1", m_tdata, 64'hB01);
        check("trim_B1_tlast", m_tlast, 0);
        tick(); #1;
        check("trim_B2", m_tdata, 64'hB02);
        check("trim_B2_tlast", m_tlast, 1);
        tick(); #1;
        check("trim_done_mvalid", m_tvalid, 0);
`ifdef CMS_AXIS_DOWNSIZER_STATS_EN
        check("stats_items_trim", items_sent, 2);
        check("stats_beats_trim", beats_sent, 6);
`endif

        // ---------------- active_words=20 behaves as 16 ----------------
        tick();
        s_tdata  = mk_item(64'hC00);
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 0) s_tvalid = 1'b0;
`ifdef CMS_AXIS_DOWNSIZER_STATS_EN
            stats_clear = (k == 2);
`endif
            #1;
            check($sformatf("over_data%0d", k), m_tdata, 64'hC00 + 64'(k));
            check($sformatf("over_tlast%0d", k), m_tlast, (k == 15));
`ifdef CMS_AXIS_DOWNSIZER_STATS_EN
            if (k == 3) begin
                check("stats_items_clr", items_sent, 0);
                check("stats_beats_clr", beats_sent, 0);
            end
`endif
        end
        tick(); #1;
        check("over_done_mvalid", m_tvalid, 0);
`ifdef CMS_AXIS_DOWNSIZER_STATS_EN
        check("stats_items_over", items_sent, 1);
        check("stats_beats_over", beats_sent, 13);
`endif

        // ---------------- backpressure ----------------
        tick();
        active_words = 4;
        s_tdata      = mk_item(64'hD00);
        s_tlast      = 1'b1;
        s_tvalid     = 1'b1;
        bp_idx = 0;
        bp_cyc = 0;
        while (bp_idx < 4 && bp_cyc < 40) begin
            tick();
            s_tvalid = 1'b0;
            m_tready = bp_pat[bp_cyc % 4];
            #1;
            check($sformatf("bp_mvalid_c%0d", bp_cyc), m_tvalid, 1);
            check($sformatf("bp_data_c%0d", bp_cyc), m_tdata, 64'hD00 + 64'(bp_idx));
            check($sformatf("bp_tlast_c%0d", bp_cyc), m_tlast, (bp_idx == 3));
            check($sformatf("bp_sready_c%0d", bp_cyc), s_tready, (bp_idx == 3 && m_tready));
            if (m_tready) bp_idx++;
            bp_cyc++;
        end
        check("bp_words_done", 64'(bp_idx), 4);
        check("bp_cycles", 64'(bp_cyc), 8);
        tick();
        m_tready = 1'b1;
        #1;
        check("bp_done_mvalid", m_tvalid, 0);

        // ---------------- single-word mode, full rate ----------------
        tick();
        active_words = 1;
        s_tdata      = mk_item(64'h1000);
        s_tlast      = 1'b0;
        s_tvalid     = 1'b1;
        #1;
        check("single_cap_sready", s_tready, 1);
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (j < 8) begin
                s_tdata = mk_item(64'h1000 + 64'(j) * 16);
                s_tlast = j[0];
            end else begin
                s_tvalid = 1'b0;
            end
            #1;
            check($sformatf("single_mvalid%0d", j-1), m_tvalid, 1);
            check($sformatf("single_data%0d", j-1), m_tdata, 64'h1000 + 64'(j-1) * 16);
            check($sformatf("single_tlast%0d", j-1), m_tlast, (j-1) % 2);
            check($sformatf("single_sready%0d", j-1), s_tready, 1);
        end
        tick(); #1;
        check("single_done_mvalid", m_tvalid, 0);

        // ---------------- reset in the middle of an item ----------------
        tick();
        active_words = 0;
        s_tdata      = mk_item(64'hE00);
        s_tlast      = 1'b1;
        s_tvalid     = 1'b1;
        tick();
        s_tvalid = 1'b0;
        repeat (5) tick();
        #1;
        check("mid_idx5", m_tdata, 64'hE05);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mvalid", m_tvalid, 0);
        check("mid_rst_tdata", m_tdata, 0);
        check("mid_rst_sready", s_tready, 0);
        tick();
        rst_n        = 1'b1;
        active_words = 2;
        s_tdata      = mk_item(64'hF00);
        s_tlast      = 1'b1;
        s_tvalid     = 1'b1;
        #1;
        check("mid_rel_sready", s_tready, 1);
        check("mid_rel_mvalid", m_tvalid, 0);
        tick();
        s_tvalid = 1'b0;
        #1;
        check("mid_new_F0", m_tdata, 64'hF00);
        check("mid_new_F0_tlast", m_tlast, 0);
        tick(); #1;
        check("mid_new_F1", m_tdata, 64'hF01);
        check("mid_new_F1_tlast", m_tlast, 1);
        tick(); #1;
        check("mid_done_mvalid", m_tvalid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cms_axis_downsizer

// File: doc/cms_axis_downsizer.md
Name: cms_axis_downsizer

Overview:
- Downstream stage of the continuous monitoring system (CMS) output stream.
- Accepts one wide AXI-Stream item per handshake (default 1024 bit) and serialises it into narrow beats (default 64 bit) for the AXI DMA / FIFO path.
- Sends only a runtime-programmable number of low-order words, so padding bits are not written to memory.
- Preserves item boundaries and tlast.

Parameters:
- S_DATA_WIDTH, 1024, width of the slave (input) tdata; must be an integer multiple of M_DATA_WIDTH.
- M_DATA_WIDTH, 64, width of the master (output) tdata.
- RATIO, S_DATA_WIDTH/M_DATA_WIDTH (derived localparam, 16 by default), number of words per input item.
- IDX_W, $clog2(RATIO)+1 (derived localparam), width of word index/count.

Ports:
- clk  input  1  single clock, shared with the CMS.
- rst_n  input  1  asynchronous, active-low reset.
- S_AXIS_tvalid  input  1  wide item valid (from the CMS M_AXIS_tvalid).
- S_AXIS_tready  output  1  wide item accepted.
- S_AXIS_tdata  input  S_DATA_WIDTH  wide item.
- S_AXIS_tlast  input  1  packet end marker on the wide item.
- M_AXIS_tvalid  output  1  narrow beat valid.
- M_AXIS_tready  input  1  downstream ready.
- M_AXIS_tdata  output  M_DATA_WIDTH  narrow beat.
- M_AXIS_tlast  output  1  asserted on the final beat of a wide item that carried tlast.
- active_words  input  IDX_W  words sent per item; sampled at item capture.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, buffer cleared, word index=0, S_AXIS_tready=0 while in reset, M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tlast=0. Releasing reset mid-item discards that item; no partial beats are ever resumed.
- States:
  - IDLE: buffer empty; S_AXIS_tready=1.
  - SEND: buffer holds an item; M_AXIS_tvalid=1.
- Capture:
  - Trigger: S_AXIS_tvalid && S_AXIS_tready.
  - Latches tdata, tlast and n_words = (active_words==0 || active_words>RATIO) ? RATIO : active_words.
  - Sets index=0 and moves to SEND.
  - Latency: first narrow beat is valid the cycle after capture.
- Output word select: M_AXIS_tdata = buffer[index*M_DATA_WIDTH +: M_DATA_WIDTH], least-significant word first. Driven from registered buffer/index; no combinational path from S_AXIS_tdata.
- Beat advance: on M_AXIS_tvalid && M_AXIS_tready, index increments. tdata/tvalid are held stable while M_AXIS_tready=0 (AXI rule).
- Last beat:
  - index==n_words-1.
  - M_AXIS_tlast = latched tlast on this beat only.
- S_AXIS_tready = (state==IDLE) || (state==SEND && last beat && M_AXIS_tready). This allows back-to-back items with no bubble.
- Simultaneous last-beat handshake and new capture: the new item loads and index resets to 0; state stays SEND.
- Last-beat handshake with no new item: return to IDLE.
- Throughput: n_words beats per item at one beat per clock when M_AXIS_tready=1. With n_words=1 this is full rate, one item per cycle.
- active_words changes mid-item have no effect until the next capture.
- No data is dropped. Upstream backpressure is the only flow control.

Optional Feature:
- Macro: CMS_AXIS_DOWNSIZER_STATS_EN.
- Defined:
  - Adds output ports items_sent [31:0] and beats_sent [31:0], plus input stats_clear.
  - items_sent increments on each last-beat handshake; beats_sent increments on each M handshake.
  - Both wrap at 2^32 and reset to 0 on rst_n=0 or stats_clear=1 (clear wins over increment in the same cycle).
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cms_axis_pkg:
  - Default width localparams (CMS_AXI_DATA_WIDTH=1024, CMS_DMA_DATA_WIDTH=64).
  - typedef enum logic {IDLE, SEND} downsizer_state_t.
- No sub-module required. If the stats feature is enabled, an optional cms_stat_counter (32-bit wrap/clear counter, instantiated twice) is natural.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-SEND (index=5).
  - Response: M_AXIS_tvalid=0 immediately (async); after release S_AXIS_tready=1, and the next item starts at word 0.
- Full-width item:
  - Stimulus: active_words=0, one item with words 0x00..0F, tlast=1, M_AXIS_tready=1.
  - Response: 16 beats 0x00..0x0F in order on consecutive cycles, tlast only on beat 16.
- Trimmed items:
  - Stimulus: active_words=3, two back-to-back items A (tlast=0) and B (tlast=1).
  - Response: beats A0,A1,A2,B0,B1,B2 with no idle cycle between items, tlast only on B2. An active_words value of 20 behaves as 16.
- Backpressure:
  - Stimulus: active_words=4, M_AXIS_tready toggling 1,0,0,1,...
  - Response: tdata/tlast stable during stalls, all 4 words delivered, S_AXIS_tready=0 until the final handshake.
- Single-word mode:
  - Stimulus: active_words=1, 8 items with S_AXIS_tvalid held 1.
  - Response: 8 beats in 8 consecutive cycles; tlast copied per item.
- Stats (CMS_AXIS_DOWNSIZER_STATS_EN):
  - Stimulus: after the trimmed-items scenario.
  - Response: items_sent=2, beats_sent=6; stats_clear asserted in the same cycle as a beat → both read 0.
